// File: rtl/updown_pkg.sv
// Shared types and helpers for the up/down counter input conditioning stage.
// Quadrature decode table and debounce counter sizing live here.
package updown_pkg;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_UP,
    STEP_DN
  } step_e;

  typedef enum logic [1:0] {
    QD_NONE,
    QD_INC,
    QD_DEC,
    QD_ILL
  } quad_e;

  function automatic int db_cnt_w(input int cycles);
    return $clog2(cycles + 1);
  endfunction

  function automatic quad_e quad_decode(
    input logic [1:0] prev_ab,
    input logic [1:0] cur_ab
  );
    quad_e q;
    unique case ({prev_ab, cur_ab})
      4'b0001, 4'b0111,
      4'b1110, 4'b1000: q = QD_INC;
      4'b0010, 4'b1011,
      4'b1101, 4'b0100: q = QD_DEC;
      4'b0000, 4'b0101,
      4'b1111, 4'b1010: q = QD_NONE;
      default:          q = QD_ILL;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer for one bit.
// The debounced bit follows the synced bit after DB_CYCLES mismatching cycles.
module input_debounce
  import updown_pkg::*;
#(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db
);

  localparam int CW = db_cnt_w(DB_CYCLES);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      cnt  <= '0;
      db   <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == db) begin
        cnt <= '0;
      // this edge is the one where the count would reach DB_CYCLES
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        db  <= sync[1];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/updown_input_cond.sv
// Encoder/button conditioning: debounce, quadrature decode, detent
// accumulation and combining into single-cycle up/down step pulses.
module updown_input_cond
  import updown_pkg::*;
#(
  parameter int DB_CYCLES  = 16,
  parameter int DETENT_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enc_a,
  input  logic enc_b,
  input  logic btn_up,
  input  logic btn_dn,
  output logic up_pulse,
  output logic dn_pulse,
  output logic err
);

  localparam logic signed [3:0] DIV_P = 4'(DETENT_DIV);
  localparam logic signed [3:0] DIV_N = -DIV_P;

  logic a_db;
  logic b_db;
  logic up_db;
  logic dn_db;

  input_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_a (
    .clk(clk), .rst(rst), .raw(enc_a), .db(a_db)
  );
  input_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_b (
    .clk(clk), .rst(rst), .raw(enc_b), .db(b_db)
  );
  input_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
    .clk(clk), .rst(rst), .raw(btn_up), .db(up_db)
  );
  input_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dn (
    .clk(clk), .rst(rst), .raw(btn_dn), .db(dn_db)
  );

  logic [1:0]        cur_ab;
  logic [1:0]        prev_ab;
  logic              primed;
  logic              up_prev;
  logic              dn_prev;
  logic signed [3:0] acc;
  logic signed [3:0] acc_nxt;
  quad_e             quad;
  logic              enc_up;
  logic              enc_dn;
  logic              btn_up_ev;
  logic              btn_dn_ev;
  logic [1:0]        n_up;
  logic [1:0]        n_dn;
  step_e             step;

  assign cur_ab = {a_db, b_db};

  always_comb begin
    quad    = primed ? quad_decode(prev_ab, cur_ab) : QD_NONE;
    acc_nxt = acc;
    enc_up  = 1'b0;
    enc_dn  = 1'b0;
    unique case (quad)
      QD_INC: begin
        if (acc + 4'sd1 == DIV_P) begin
          enc_up  = 1'b1;
          acc_nxt = '0;
        end else begin
          acc_nxt = acc + 4'sd1;
        end
      end
      QD_DEC: begin
        if (acc - 4'sd1 == DIV_N) begin
          enc_dn  = 1'b1;
          acc_nxt = '0;
        end else begin
          acc_nxt = acc - 4'sd1;
        end
      end
      QD_ILL:  acc_nxt = '0;
      default: acc_nxt = acc;
    endcase
  end

  always_comb begin
    btn_up_ev = primed & up_db & ~up_prev;
    btn_dn_ev = primed & dn_db & ~dn_prev;
    n_up = {1'b0, enc_up} + {1'b0, btn_up_ev};
    n_dn = {1'b0, enc_dn} + {1'b0, btn_dn_ev};
    if (n_up > n_dn)      step = STEP_UP;
    else if (n_up < n_dn) step = STEP_DN;
    else                  step = STEP_NONE;
  end

  // the priming cycle only captures history; quad and button events are gated off
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_ab  <= '0;
      primed   <= 1'b0;
      acc      <= '0;
      up_prev  <= 1'b0;
      dn_prev  <= 1'b0;
      up_pulse <= 1'b0;
      dn_pulse <= 1'b0;
      err      <= 1'b0;
    end else begin
      prev_ab  <= cur_ab;
      primed   <= 1'b1;
      acc      <= acc_nxt;
      up_prev  <= up_db;
      dn_prev  <= dn_db;
      up_pulse <= (step == STEP_UP);
      dn_pulse <= (step == STEP_DN);
      err      <= (quad == QD_ILL);
    end
  end

endmodule
